// File: rtl/dram_sc_pkg.sv
// dram_sc_pkg: shared constants and types for the DRAM-to-sctag read-return
// path. It holds the pending-queue depth default, the beat and ECC widths,
// the number of chunks per cache line and the request-tag width.
// Ports: none (package).
package dram_sc_pkg;

  localparam int RDQ_DEPTH_DEF   = 4;
  localparam int BEAT_W          = 128;
  localparam int ECC_W           = 28;
  localparam int CHUNKS_PER_LINE = 4;
  localparam int REQ_ID_W        = 3;
  localparam int CHUNK_W         = $clog2(CHUNKS_PER_LINE);

  typedef logic [CHUNK_W-1:0]  chunk_t;
  typedef logic [REQ_ID_W-1:0] req_id_t;

  // One return beat as it travels down the r0..r2 data pipeline.
  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [ECC_W-1:0]  ecc;
    logic              secc;
    logic              mecc;
  } beat_t;

  // The final beat of a line retires the request at the queue head.
  function automatic logic is_last_chunk(input chunk_t c);
    return c == chunk_t'(CHUNKS_PER_LINE - 1);
  endfunction

endpackage

// File: rtl/dram_sc_rd_ret_if.sv
// dram_sc_rd_ret_if: bundles the sctag request side, the DRAM core return
// side and the sctag/scbuf result side of the read-return block.
// Ports: none; signals are reached through the modports.
//   master : the surrounding system (drives requests and DRAM beats)
//   slave  : dram_sc_rd_ret (drives ack, r0 tag info, r2 data, error flag)
//
// Handshake: sctag_dram_rd_req is a request level held high until the
// one-cycle dram_sctag_rd_ack pulse is seen; the ack follows acceptance by
// one cycle and the requester may drop or change the request in the ack
// cycle. DRAM beats (dram_rd_data_vld) have no backpressure: each valid
// cycle is one beat and must be consumed.
interface dram_sc_rd_ret_if;
  import dram_sc_pkg::*;

  logic              sctag_dram_rd_req;
  logic              sctag_dram_rd_dummy_req;
  req_id_t           sctag_dram_rd_req_id;
  logic              dram_rd_data_vld;
  logic [BEAT_W-1:0] dram_rd_data;
  logic [ECC_W-1:0]  dram_rd_ecc;
  logic              dram_rd_secc;
  logic              dram_rd_mecc;

  logic              dram_sctag_rd_ack;
  logic              dram_sctag_data_vld_r0;
  chunk_t            dram_sctag_chunk_id_r0;
  req_id_t           dram_sctag_rd_req_id_r0;
  logic [BEAT_W-1:0] dram_scbuf_data_r2;
  logic [ECC_W-1:0]  dram_scbuf_ecc_r2;
  logic              dram_sctag_secc_err_r2;
  logic              dram_sctag_mecc_err_r2;
  logic              dram_rdret_proto_err;

  modport master (
    output sctag_dram_rd_req, sctag_dram_rd_dummy_req, sctag_dram_rd_req_id,
    output dram_rd_data_vld, dram_rd_data, dram_rd_ecc, dram_rd_secc, dram_rd_mecc,
    input  dram_sctag_rd_ack, dram_sctag_data_vld_r0, dram_sctag_chunk_id_r0,
    input  dram_sctag_rd_req_id_r0, dram_scbuf_data_r2, dram_scbuf_ecc_r2,
    input  dram_sctag_secc_err_r2, dram_sctag_mecc_err_r2, dram_rdret_proto_err
  );

  modport slave (
    input  sctag_dram_rd_req, sctag_dram_rd_dummy_req, sctag_dram_rd_req_id,
    input  dram_rd_data_vld, dram_rd_data, dram_rd_ecc, dram_rd_secc, dram_rd_mecc,
    output dram_sctag_rd_ack, dram_sctag_data_vld_r0, dram_sctag_chunk_id_r0,
    output dram_sctag_rd_req_id_r0, dram_scbuf_data_r2, dram_scbuf_ecc_r2,
    output dram_sctag_secc_err_r2, dram_sctag_mecc_err_r2, dram_rdret_proto_err
  );

endinterface

// File: rtl/dram_sc_idq.sv
// dram_sc_idq: synchronous FIFO holding the tags of accepted, not yet
// returned reads, in request order.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the queue)
//   push_i       : write push_data_i at the tail (ignored when full)
//   push_data_i  : tag to enqueue
//   pop_i        : drop the head entry (ignored when empty)
//   full_o       : count == DEPTH
//   empty_o      : count == 0
//   head_o       : oldest tag; only meaningful when not empty
// Push and pop in the same cycle both take effect and leave count unchanged.
module dram_sc_idq #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage is not reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/dram_sc_rd_ret.sv
// dram_sc_rd_ret: accepts sctag read requests, remembers the tags of real
// (non-dummy) reads in order, and tags each 4-beat DRAM return with its
// request id and chunk index. Tag information is presented at r0 (one cycle
// after the beat), data/ECC/error flags at r2 (three cycles after the beat).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : dram_sc_rd_ret_if.slave (requests, DRAM beats, results)
// A beat arriving with no pending request is dropped and latches the sticky
// protocol-error flag until reset.
module dram_sc_rd_ret
  import dram_sc_pkg::*;
#(
  parameter int RDQ_DEPTH = RDQ_DEPTH_DEF
) (
  input logic               clk,
  input logic               rst,
  dram_sc_rd_ret_if.slave   bus
);

  logic    idq_full, idq_empty;
  req_id_t idq_head;

  logic    ack_q, ack_d;
  logic    accept, push, beat_ok, beat_drop, pop;
  chunk_t  chunk_q, chunk_d;
  logic    proto_q, proto_d;

  // r0 tag stage and the three-deep data pipeline (r0 -> r1 -> r2).
  logic    vld_r0_q, vld_r1_q, vld_r2_q;
  chunk_t  chunk_r0_q;
  req_id_t id_r0_q;
  beat_t   beat_in, beat_r0_q, beat_r1_q, beat_r2_q;

  always_comb begin
    beat_in = '{data: bus.dram_rd_data, ecc: bus.dram_rd_ecc,
                secc: bus.dram_rd_secc, mecc: bus.dram_rd_mecc};
    // No new acceptance in the ack cycle, so a held request is acked once.
    accept    = bus.sctag_dram_rd_req & ~ack_q &
                (bus.sctag_dram_rd_dummy_req | ~idq_full);
    push      = accept & ~bus.sctag_dram_rd_dummy_req;
    beat_ok   = bus.dram_rd_data_vld & ~idq_empty;
    beat_drop = bus.dram_rd_data_vld & idq_empty;
    pop       = beat_ok & is_last_chunk(chunk_q);
    ack_d     = accept;
    chunk_d   = beat_ok ? chunk_q + chunk_t'(1) : chunk_q;
    proto_d   = proto_q | beat_drop;
  end

  dram_sc_idq #(
    .DEPTH (RDQ_DEPTH),
    .W     (REQ_ID_W)
  ) u_idq (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (bus.sctag_dram_rd_req_id),
    .pop_i       (pop),
    .full_o      (idq_full),
    .empty_o     (idq_empty),
    .head_o      (idq_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= 1'b0;
      chunk_q    <= '0;
      proto_q    <= 1'b0;
      vld_r0_q   <= 1'b0;
      vld_r1_q   <= 1'b0;
      vld_r2_q   <= 1'b0;
      chunk_r0_q <= '0;
      id_r0_q    <= '0;
      beat_r0_q  <= '0;
      beat_r1_q  <= '0;
      beat_r2_q  <= '0;
    end else begin
      ack_q      <= ack_d;
      chunk_q    <= chunk_d;
      proto_q    <= proto_d;
      vld_r0_q   <= beat_ok;
      vld_r1_q   <= vld_r0_q;
      vld_r2_q   <= vld_r1_q;
      // r0 tag fields read as zero whenever no beat is presented.
      chunk_r0_q <= beat_ok ? chunk_q : '0;
      id_r0_q    <= beat_ok ? idq_head : '0;
      // Data flops only move with a valid beat and otherwise hold.
      if (beat_ok)  beat_r0_q <= beat_in;
      if (vld_r0_q) beat_r1_q <= beat_r0_q;
      if (vld_r1_q) beat_r2_q <= beat_r1_q;
    end
  end

  assign bus.dram_sctag_rd_ack       = ack_q;
  assign bus.dram_sctag_data_vld_r0  = vld_r0_q;
  assign bus.dram_sctag_chunk_id_r0  = chunk_r0_q;
  assign bus.dram_sctag_rd_req_id_r0 = id_r0_q;
  assign bus.dram_scbuf_data_r2      = beat_r2_q.data;
  assign bus.dram_scbuf_ecc_r2       = beat_r2_q.ecc;
  // Held data may carry stale error bits; qualify them with the r2 valid.
  assign bus.dram_sctag_secc_err_r2  = vld_r2_q & beat_r2_q.secc;
  assign bus.dram_sctag_mecc_err_r2  = vld_r2_q & beat_r2_q.mecc;
  assign bus.dram_rdret_proto_err    = proto_q;

endmodule

// File: tb/tb_dram_sc_rd_ret.sv
// tb_dram_sc_rd_ret: directed self-checking bench for dram_sc_rd_ret.
// Inputs change 1ns after the rising edge and outputs are read at the same
// point, so every registered output seen in a cycle reflects the inputs of
// the previous cycle.
module tb_dram_sc_rd_ret;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dram_sc_rd_ret_if bus_if();

  dram_sc_rd_ret #(.RDQ_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- clock/reset and drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus_if.sctag_dram_rd_req       = 1'b0;
    bus_if.sctag_dram_rd_dummy_req = 1'b0;
    bus_if.sctag_dram_rd_req_id    = 3'd0;
    bus_if.dram_rd_data_vld        = 1'b0;
    bus_if.dram_rd_data            = '0;
    bus_if.dram_rd_ecc             = '0;
    bus_if.dram_rd_secc            = 1'b0;
    bus_if.dram_rd_mecc            = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [127:0] beat_data(input logic [2:0] id, input logic [1:0] ch);
    logic [7:0] b;
    b = {1'b1, id, ch, 2'b01};
    return {16{b}};
  endfunction

  function automatic logic [27:0] beat_ecc(input logic [2:0] id, input logic [1:0] ch);
    return {20'hABCDE, 1'b0, id, 2'b00, ch};
  endfunction

  // Issue one request and expect the ack exactly one cycle later.
  task automatic request(input logic [2:0] id, input logic dummy);
    bus_if.sctag_dram_rd_req       = 1'b1;
    bus_if.sctag_dram_rd_dummy_req = dummy;
    bus_if.sctag_dram_rd_req_id    = id;
    tick();
    vectors++;
    if (bus_if.dram_sctag_rd_ack !== 1'b1) begin
      $display("FAIL req_ack id%0d: got %0b want 1", id, bus_if.dram_sctag_rd_ack); miscompares++;
    end
    bus_if.sctag_dram_rd_req       = 1'b0;
    bus_if.sctag_dram_rd_dummy_req = 1'b0;
    tick();
    vectors++;
    if (bus_if.dram_sctag_rd_ack !== 1'b0) begin
      $display("FAIL ack_one_cycle id%0d: got %0b want 0", id, bus_if.dram_sctag_rd_ack); miscompares++;
    end
  endtask

  // Four beats of one line starting in the current cycle (k=0); r0 is
  // checked at k=1..5 and r2 at k=3..6. ack_k is the k where an ack is due.
  task automatic burst(input logic [2:0] id, input int secc_c, input int mecc_c, input int ack_k);
    for (int k = 0; k < 7; k++) begin
      logic       e_vld, e_err;
      logic [1:0] e_ch;
      logic [2:0] e_id;
      if (k < 4) begin
        bus_if.dram_rd_data_vld = 1'b1;
        bus_if.dram_rd_data     = beat_data(id, 2'(k));
        bus_if.dram_rd_ecc      = beat_ecc(id, 2'(k));
        bus_if.dram_rd_secc     = (k == secc_c);
        bus_if.dram_rd_mecc     = (k == mecc_c);
      end else begin
        bus_if.dram_rd_data_vld = 1'b0;
        bus_if.dram_rd_data     = '0;
        bus_if.dram_rd_ecc      = '0;
        bus_if.dram_rd_secc     = 1'b0;
        bus_if.dram_rd_mecc     = 1'b0;
      end
      if (k >= 1 && k <= 5) begin
        e_vld = (k <= 4);
        e_ch  = (k <= 4) ? 2'(k - 1) : 2'd0;
        e_id  = (k <= 4) ? id : 3'd0;
        vectors += 3;
        if (bus_if.dram_sctag_data_vld_r0 !== e_vld) begin
          $display("FAIL r0_vld id%0d k%0d: got %0b want %0b", id, k, bus_if.dram_sctag_data_vld_r0, e_vld); miscompares++;
        end
        if (bus_if.dram_sctag_chunk_id_r0 !== e_ch) begin
          $display("FAIL r0_chunk id%0d k%0d: got %0d want %0d", id, k, bus_if.dram_sctag_chunk_id_r0, e_ch); miscompares++;
        end
        if (bus_if.dram_sctag_rd_req_id_r0 !== e_id) begin
          $display("FAIL r0_id id%0d k%0d: got %0d want %0d", id, k, bus_if.dram_sctag_rd_req_id_r0, e_id); miscompares++;
        end
      end
      if (k >= 3) begin
        vectors += 4;
        if (bus_if.dram_scbuf_data_r2 !== beat_data(id, 2'(k - 3))) begin
          $display("FAIL r2_data id%0d k%0d: got %0h want %0h", id, k, bus_if.dram_scbuf_data_r2, beat_data(id, 2'(k - 3))); miscompares++;
        end
        if (bus_if.dram_scbuf_ecc_r2 !== beat_ecc(id, 2'(k - 3))) begin
          $display("FAIL r2_ecc id%0d k%0d: got %0h want %0h", id, k, bus_if.dram_scbuf_ecc_r2, beat_ecc(id, 2'(k - 3))); miscompares++;
        end
        e_err = ((k - 3) == secc_c);
        if (bus_if.dram_sctag_secc_err_r2 !== e_err) begin
          $display("FAIL r2_secc id%0d k%0d: got %0b want %0b", id, k, bus_if.dram_sctag_secc_err_r2, e_err); miscompares++;
        end
        e_err = ((k - 3) == mecc_c);
        if (bus_if.dram_sctag_mecc_err_r2 !== e_err) begin
          $display("FAIL r2_mecc id%0d k%0d: got %0b want %0b", id, k, bus_if.dram_sctag_mecc_err_r2, e_err); miscompares++;
        end
      end
      vectors++;
      if (bus_if.dram_sctag_rd_ack !== (k == ack_k)) begin
        $display("FAIL burst_ack id%0d k%0d: got %0b want %0b", id, k, bus_if.dram_sctag_rd_ack, (k == ack_k)); miscompares++;
      end
      tick();
    end
  endtask

  // Everything visible must be zero (after reset).
  task automatic check_all_zero(input string tag);
    logic [127:0] z128;
    z128 = '0;
    vectors += 9;
    if (bus_if.dram_sctag_rd_ack !== 1'b0) begin
      $display("FAIL %s ack: got %0b want 0", tag, bus_if.dram_sctag_rd_ack); miscompares++;
    end
    if (bus_if.dram_sctag_data_vld_r0 !== 1'b0) begin
      $display("FAIL %s vld_r0: got %0b want 0", tag, bus_if.dram_sctag_data_vld_r0); miscompares++;
    end
    if (bus_if.dram_sctag_chunk_id_r0 !== 2'd0) begin
      $display("FAIL %s chunk_r0: got %0d want 0", tag, bus_if.dram_sctag_chunk_id_r0); miscompares++;
    end
    if (bus_if.dram_sctag_rd_req_id_r0 !== 3'd0) begin
      $display("FAIL %s id_r0: got %0d want 0", tag, bus_if.dram_sctag_rd_req_id_r0); miscompares++;
    end
    if (bus_if.dram_scbuf_data_r2 !== z128) begin
      $display("FAIL %s data_r2: got %0h want 0", tag, bus_if.dram_scbuf_data_r2); miscompares++;
    end
    if (bus_if.dram_scbuf_ecc_r2 !== 28'd0) begin
      $display("FAIL %s ecc_r2: got %0h want 0", tag, bus_if.dram_scbuf_ecc_r2); miscompares++;
    end
    if (bus_if.dram_sctag_secc_err_r2 !== 1'b0) begin
      $display("FAIL %s secc_r2: got %0b want 0", tag, bus_if.dram_sctag_secc_err_r2); miscompares++;
    end
    if (bus_if.dram_sctag_mecc_err_r2 !== 1'b0) begin
      $display("FAIL %s mecc_r2: got %0b want 0", tag, bus_if.dram_sctag_mecc_err_r2); miscompares++;
    end
    if (bus_if.dram_rdret_proto_err !== 1'b0) begin
      $display("FAIL %s proto_err: got %0b want 0", tag, bus_if.dram_rdret_proto_err); miscompares++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    check_all_zero("reset");
  endtask

  // Request id 5 at cycle 0, beats at cycles 10..13.
  task automatic test_single();
    request(3'd5, 1'b0);            // returns in cycle 2
    repeat (8) tick();              // cycle 10
    burst(3'd5, -1, -1, -1);        // returns in cycle 17
    vectors += 2;
    if (bus_if.dram_scbuf_data_r2 !== beat_data(3'd5, 2'd3)) begin
      $display("FAIL data_hold: got %0h want %0h", bus_if.dram_scbuf_data_r2, beat_data(3'd5, 2'd3)); miscompares++;
    end
    if (bus_if.dram_rdret_proto_err !== 1'b0) begin
      $display("FAIL single_proto: got %0b want 0", bus_if.dram_rdret_proto_err); miscompares++;
    end
  endtask

  task automatic test_ecc_flags();
    request(3'd2, 1'b0);
    burst(3'd2, 0, 2, -1);
  endtask

  task automatic test_full_and_dummy();
    request(3'd1, 1'b0);
    request(3'd2, 1'b0);
    request(3'd3, 1'b0);
    request(3'd4, 1'b0);
    request(3'd0, 1'b1);            // dummy: acked even though full
    bus_if.sctag_dram_rd_req    = 1'b1;
    bus_if.sctag_dram_rd_req_id = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus_if.dram_sctag_rd_ack !== 1'b0) begin
        $display("FAIL full_hold c%0d: got %0b want 0", i, bus_if.dram_sctag_rd_ack); miscompares++;
      end
    end
    // Chunk 3 of id 1 at k=3 pops; accept at k=4, ack visible at k=5.
    burst(3'd1, -1, -1, 5);
    bus_if.sctag_dram_rd_req = 1'b0;
    burst(3'd2, -1, -1, -1);
    burst(3'd3, -1, -1, -1);
    burst(3'd4, -1, -1, -1);
    burst(3'd6, -1, -1, -1);
    vectors++;
    if (bus_if.dram_rdret_proto_err !== 1'b0) begin
      $display("FAIL full_proto: got %0b want 0", bus_if.dram_rdret_proto_err); miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ids [2];
    ids[0] = 3'd3;
    ids[1] = 3'd7;
    request(ids[0], 1'b0);
    request(ids[1], 1'b0);
    for (int k = 0; k < 11; k++) begin
      int b;
      if (k < 8) begin
        bus_if.dram_rd_data_vld = 1'b1;
        bus_if.dram_rd_data     = beat_data(ids[k / 4], 2'(k % 4));
        bus_if.dram_rd_ecc      = beat_ecc(ids[k / 4], 2'(k % 4));
      end else begin
        drive_idle();
      end
      if (k >= 1 && k <= 8) begin
        b = k - 1;
        vectors += 3;
        if (bus_if.dram_sctag_data_vld_r0 !== 1'b1) begin
          $display("FAIL b2b_vld k%0d: got %0b want 1", k, bus_if.dram_sctag_data_vld_r0); miscompares++;
        end
        if (bus_if.dram_sctag_chunk_id_r0 !== 2'(b % 4)) begin
          $display("FAIL b2b_chunk k%0d: got %0d want %0d", k, bus_if.dram_sctag_chunk_id_r0, b % 4); miscompares++;
        end
        if (bus_if.dram_sctag_rd_req_id_r0 !== ids[b / 4]) begin
          $display("FAIL b2b_id k%0d: got %0d want %0d", k, bus_if.dram_sctag_rd_req_id_r0, ids[b / 4]); miscompares++;
        end
      end
      if (k >= 3) begin
        b = k - 3;
        vectors++;
        if (bus_if.dram_scbuf_data_r2 !== beat_data(ids[b / 4], 2'(b % 4))) begin
          $display("FAIL b2b_data k%0d: got %0h want %0h", k, bus_if.dram_scbuf_data_r2, beat_data(ids[b / 4], 2'(b % 4))); miscompares++;
        end
      end
      if (k == 9) begin
        vectors++;
        if (bus_if.dram_sctag_data_vld_r0 !== 1'b0) begin
          $display("FAIL b2b_vld_end: got %0b want 0", bus_if.dram_sctag_data_vld_r0); miscompares++;
        end
      end
      tick();
    end
  endtask

  task automatic test_proto_err();
    // Queue is empty here: this beat must be dropped.
    bus_if.dram_rd_data_vld = 1'b1;
    bus_if.dram_rd_data     = beat_data(3'd1, 2'd0);
    bus_if.dram_rd_secc     = 1'b1;
    bus_if.dram_rd_mecc     = 1'b1;
    tick();
    drive_idle();
    vectors += 2;
    if (bus_if.dram_sctag_data_vld_r0 !== 1'b0) begin
      $display("FAIL proto_vld_r0: got %0b want 0", bus_if.dram_sctag_data_vld_r0); miscompares++;
    end
    if (bus_if.dram_rdret_proto_err !== 1'b1) begin
      $display("FAIL proto_set: got %0b want 1", bus_if.dram_rdret_proto_err); miscompares++;
    end
    tick();
    tick();                           // r2 cycle of the dropped beat
    vectors += 2;
    if (bus_if.dram_sctag_secc_err_r2 !== 1'b0 || bus_if.dram_sctag_mecc_err_r2 !== 1'b0) begin
      $display("FAIL proto_err_r2: got %0b%0b want 00", bus_if.dram_sctag_secc_err_r2, bus_if.dram_sctag_mecc_err_r2); miscompares++;
    end
    if (bus_if.dram_scbuf_data_r2 !== beat_data(3'd7, 2'd3)) begin
      $display("FAIL proto_data_hold: got %0h want %0h", bus_if.dram_scbuf_data_r2, beat_data(3'd7, 2'd3)); miscompares++;
    end
    repeat (5) tick();
    vectors++;
    if (bus_if.dram_rdret_proto_err !== 1'b1) begin
      $display("FAIL proto_sticky: got %0b want 1", bus_if.dram_rdret_proto_err); miscompares++;
    end
    do_reset();
    check_all_zero("proto_reset");
  endtask

  task automatic test_reset_mid_burst();
    request(3'd4, 1'b0);
    bus_if.dram_rd_data_vld = 1'b1;
    bus_if.dram_rd_data     = beat_data(3'd4, 2'd0);
    bus_if.dram_rd_ecc      = beat_ecc(3'd4, 2'd0);
    tick();
    bus_if.dram_rd_data     = beat_data(3'd4, 2'd1);
    bus_if.dram_rd_ecc      = beat_ecc(3'd4, 2'd1);
    vectors++;
    if (bus_if.dram_sctag_chunk_id_r0 !== 2'd0 || bus_if.dram_sctag_rd_req_id_r0 !== 3'd4) begin
      $display("FAIL mid_c0: got %0d/%0d want 0/4", bus_if.dram_sctag_chunk_id_r0, bus_if.dram_sctag_rd_req_id_r0); miscompares++;
    end
    tick();
    drive_idle();
    rst = 1'b1;
    vectors++;
    if (bus_if.dram_sctag_chunk_id_r0 !== 2'd1 || bus_if.dram_sctag_data_vld_r0 !== 1'b1) begin
      $display("FAIL mid_c1: got %0d/%0b want 1/1", bus_if.dram_sctag_chunk_id_r0, bus_if.dram_sctag_data_vld_r0); miscompares++;
    end
    tick();
    rst = 1'b0;
    check_all_zero("mid_reset");
    request(3'd6, 1'b0);
    burst(3'd6, -1, -1, -1);
  endtask

  task automatic test_reset_pending_ack();
    bus_if.sctag_dram_rd_req    = 1'b1;
    bus_if.sctag_dram_rd_req_id = 3'd2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_idle();
    vectors++;
    if (bus_if.dram_sctag_rd_ack !== 1'b0) begin
      $display("FAIL pend_ack: got %0b want 0", bus_if.dram_sctag_rd_ack); miscompares++;
    end
    // Nothing was queued, so a beat now is a protocol error.
    bus_if.dram_rd_data_vld = 1'b1;
    tick();
    drive_idle();
    vectors++;
    if (bus_if.dram_rdret_proto_err !== 1'b1 || bus_if.dram_sctag_data_vld_r0 !== 1'b0) begin
      $display("FAIL pend_empty: got %0b/%0b want 1/0", bus_if.dram_rdret_proto_err, bus_if.dram_sctag_data_vld_r0); miscompares++;
    end
    do_reset();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_ecc_flags();
    test_full_and_dummy();
    test_back_to_back();
    test_proto_err();
    test_reset_mid_burst();
    test_reset_pending_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
